seq_slice_n: RTL and testbench
==============================

Name: seq_slice_n

Overview:
Parametrised successor to the 4-bit microprogram sequencer slice. Selects the next microaddress from four sources and holds it in an internal PC with optional increment. Adds a configurable-depth LIFO with full/empty/error flags, a loadable/decrementing address-counter register, and synchronous reset. Sits between the microcode ROM address bus and the control store pipeline; `cout` allows slices to be cascaded.

Parameters:
- WIDTH, 4: address width in bits (>=2).
- DEPTH, 4: subroutine stack depth in entries (>=2, need not be a power of two).
- CNTW, $clog2(DEPTH+1): width of the stack occupancy count (derived; do not override).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- din  in  WIDTH  direct/branch address input.
- sel  in  2  next-address source: 0 PC, 1 AR, 2 top-of-stack, 3 din.
- zero_n  in  1  active-low: forces yout to 0.
- cin  in  1  PC increment enable (carry in).
- ar_ld  in  1  load AR from din.
- ar_dec  in  1  decrement AR.
- stk_en  in  1  stack operation enable.
- stk_push  in  1  when stk_en=1: 1 push, 0 pop.
- clr_err  in  1  clear sticky stack_err.
- yout  out  WIDTH  next microaddress (combinational).
- cout  out  1  1 when yout is all ones (cascade carry).
- ar_zero  out  1  1 when AR == 0.
- stack_full  out  1  count == DEPTH.
- stack_empty  out  1  count == 0.
- stack_err  out  1  sticky overflow/underflow flag.
- sp_count  out  CNTW  current stack occupancy.

Behaviour:
- **Reset** (clock edge with reset=1): PC=0, AR=0, count=0, stack_err=0. Stack storage is not cleared; it is unobservable while empty. Reset has priority over all other inputs, including mid-push or mid-pop.
- **Combinational path:**
  - mux = PC, AR, TOS or din according to sel.
  - TOS = entry[count-1] when count>0, else 0.
  - yout = zero_n ? mux : 0.
  - cout = (yout == {WIDTH{1'b1}}).
- **PC update** (every non-reset edge): PC <= yout + cin, modulo 2^WIDTH. All-ones + 1 wraps to 0.
- **AR update:**
  - ar_ld=1: AR <= din.
  - else ar_dec=1: AR <= AR-1, saturating at 0.
  - ar_ld has priority over ar_dec.
  - ar_zero is combinational from the AR register.
- **Push** (stk_en=1, stk_push=1):
  - If not full: entry[count] <= current PC (the value before this edge's update), count <= count+1.
  - If full: storage and count unchanged; stack_err <= 1.
- **Pop** (stk_en=1, stk_push=0):
  - If not empty: count <= count-1.
  - If empty: count unchanged; stack_err <= 1.
- **Stack source during a stack op:** with sel=2 in the same cycle as a pop, yout is the pre-pop TOS (return). With sel=2 in the same cycle as a push, yout is the pre-push TOS.
- **stack_err:** sticky; cleared only by reset or clr_err=1. If clr_err=1 and a new error occur on the same edge, the error wins and stack_err stays 1.
- **Latency:** no added latency.
  - yout, cout and flags are combinational from registered state and current inputs.
  - State changes take effect on the next rising edge.
- **Forbidden inputs:** none; every input combination is legal and defined as above.

Decomposition:
- **Package `seq_slice_pkg`:** sel encodings as localparams SEL_PC=2'd0, SEL_AR=2'd1, SEL_STK=2'd2, SEL_DIN=2'd3, plus a stack-op enum (NOP/PUSH/POP) derived from stk_en and stk_push.
- **Sub-module `seq_lifo`** (WIDTH, DEPTH):
  - Contains storage, count, full/empty, TOS read and error-pulse output.
  - The top level holds PC, AR, the mux, the incrementer and the sticky error flag.

Test Plan:
1. **Reset and increment:** assert reset for 1 cycle, then WIDTH=4, sel=0, zero_n=1, cin=1 for 17 cycles -> yout steps 0,1..15,0. cout=1 only while yout=15.
2. **Call/return:** PC=5, sel=3, din=9, stk_en=1, push=1 -> yout=9, count=1, TOS=5. Next cycle PC=10 (cin=1); then sel=2, stk_en=1, push=0 -> yout=5, count=0, stack_empty=1.
3. **Overflow:** DEPTH=4, push 5 times with PC=1,2,3,4,5 -> after 4 pushes stack_full=1. The 5th push leaves count=4, TOS=4, and stack_err=1 held. clr_err=1 then clears it.
4. **Underflow:** on an empty stack, pop with sel=2 -> yout=0, count=0, stack_err=1. A simultaneous clr_err=1 with the pop -> stack_err stays 1.
5. **AR counter:** ar_ld=1, din=3 -> AR=3. ar_dec held for 5 cycles -> AR 2,1,0,0,0 and ar_zero=1 from the third decrement. ar_ld and ar_dec together with din=7 -> AR=7.
6. **Forced zero and reset mid-operation:** zero_n=0, sel=3, din=12, cin=1 -> yout=0 and PC=1. Asserting reset in the same cycle as a push -> count=0, PC=0, stack_err=0.

Source files
------------

// File: rtl/seq_slice_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_slice_pkg
// Purpose  : Shared encodings for the microprogram sequencer slice: next
//            address source selects and the decoded stack operation.
// Contents : SEL_* source encodings, stk_op_e enum, stk_op_decode().
// Revision : 1.0 - initial parametrised release
// ============================================================================
package seq_slice_pkg;

  localparam logic [1:0] SEL_PC  = 2'd0;
  localparam logic [1:0] SEL_AR  = 2'd1;
  localparam logic [1:0] SEL_STK = 2'd2;
  localparam logic [1:0] SEL_DIN = 2'd3;

  typedef enum logic [1:0] {
    STK_NOP  = 2'd0,
    STK_PUSH = 2'd1,
    STK_POP  = 2'd2
  } stk_op_e;

  function automatic stk_op_e stk_op_decode(input logic en, input logic push);
    if (!en)      return STK_NOP;
    else if (push) return STK_PUSH;
    else           return STK_POP;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_slice_n_lifo.sv
`default_nettype none
// ============================================================================
// Module   : seq_lifo
// Purpose  : Subroutine return-address LIFO of DEPTH entries. Refuses pushes
//            when full and pops when empty, signalling each refusal with a
//            single-cycle error pulse.
// Ports    : clock, reset         - clock, synchronous active-high reset
//            op                   - decoded stack operation
//            wdata [WIDTH]        - value pushed
//            tos   [WIDTH]        - top of stack (0 when empty)
//            count [CNTW]         - occupancy
//            full, empty          - occupancy flags
//            err_pulse            - this cycle's op was refused
// Revision : 1.0 - initial parametrised release
// ============================================================================
module seq_lifo
  import seq_slice_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  stk_op_e          op,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] tos,
  output logic [CNTW-1:0]  count,
  output logic             full,
  output logic             empty,
  output logic             err_pulse
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [CNTW-1:0]  r_count;
  logic [CNTW-1:0]  w_count_m1;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign full  = (r_count == CNTW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

  // Indices are only used while the count keeps them in range
  // (push when not full, read when not empty), so the truncation is safe.
  assign w_count_m1 = r_count - CNTW'(1);
  assign w_wr_idx   = r_count[AW-1:0];
  assign w_rd_idx   = w_count_m1[AW-1:0];

  assign w_do_push = (op == STK_PUSH) && !full;
  assign w_do_pop  = (op == STK_POP)  && !empty;
  assign err_pulse = ((op == STK_PUSH) && full) || ((op == STK_POP) && empty);

  assign tos = empty ? '0 : r_mem[w_rd_idx];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_do_push) begin
      r_count <= r_count + CNTW'(1);
    end else if (w_do_pop) begin
      r_count <= w_count_m1;
    end
  end

  // Storage is left uncleared by reset: an empty stack never exposes it.
  always_ff @(posedge clock) begin
    if (!reset && w_do_push) begin
      r_mem[w_wr_idx] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_slice_n.sv
`default_nettype none
// ============================================================================
// Module   : seq_slice_n
// Purpose  : Parametrised microprogram sequencer slice. Selects the next
//            microaddress from PC, AR, top of stack or din; holds PC with
//            optional increment, a loadable/decrementing address register,
//            and a subroutine LIFO with sticky error flag.
// Ports    : clock, reset               - clock, sync active-high reset
//            din, sel, zero_n, cin      - address input, source, force-zero, carry
//            ar_ld, ar_dec              - AR load / decrement
//            stk_en, stk_push, clr_err  - stack control, sticky error clear
//            yout, cout                 - next microaddress, all-ones carry
//            ar_zero                    - AR == 0
//            stack_full, stack_empty, stack_err, sp_count - stack status
// Revision : 1.0 - initial parametrised release
// ============================================================================
module seq_slice_n
  import seq_slice_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       sel,
  input  logic             zero_n,
  input  logic             cin,
  input  logic             ar_ld,
  input  logic             ar_dec,
  input  logic             stk_en,
  input  logic             stk_push,
  input  logic             clr_err,
  output logic [WIDTH-1:0] yout,
  output logic             cout,
  output logic             ar_zero,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err,
  output logic [CNTW-1:0]  sp_count
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ar;
  logic             r_err;
  logic [WIDTH-1:0] w_tos;
  logic [WIDTH-1:0] w_mux;
  logic             w_err_pulse;
  stk_op_e          w_op;

  assign w_op = stk_op_decode(stk_en, stk_push);

  // The LIFO pushes the PC value from before this edge, i.e. the address of
  // the calling microinstruction plus whatever increment was already applied.
  seq_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNTW  (CNTW)
  ) u_lifo (
    .clock     (clock),
    .reset     (reset),
    .op        (w_op),
    .wdata     (r_pc),
    .tos       (w_tos),
    .count     (sp_count),
    .full      (stack_full),
    .empty     (stack_empty),
    .err_pulse (w_err_pulse)
  );

  // TOS comes straight from current (pre-op) state, so a pop with SEL_STK
  // returns to the address being popped.
  always_comb begin
    w_mux = r_pc;
    case (sel)
      SEL_PC:  w_mux = r_pc;
      SEL_AR:  w_mux = r_ar;
      SEL_STK: w_mux = w_tos;
      SEL_DIN: w_mux = din;
      default: w_mux = r_pc;
    endcase
  end

  assign yout    = zero_n ? w_mux : '0;
  assign cout    = &yout;
  assign ar_zero = (r_ar == '0);
  assign stack_err = r_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc <= '0;
    end else begin
      r_pc <= yout + {{(WIDTH-1){1'b0}}, cin};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ar <= '0;
    end else if (ar_ld) begin
      r_ar <= din;
    end else if (ar_dec && !ar_zero) begin
      r_ar <= r_ar - WIDTH'(1);
    end
  end

  // A fresh error outranks a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_err_pulse) begin
      r_err <= 1'b1;
    end else if (clr_err) begin
      r_err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_slice_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_slice_n
// Purpose  : Self-checking bench for seq_slice_n against a queue-based
//            behavioural model; directed scenarios then random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_slice_n;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CNTW  = $clog2(DEPTH + 1);

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] din;
  logic [1:0]       sel;
  logic             zero_n, cin, ar_ld, ar_dec, stk_en, stk_push, clr_err;
  logic [WIDTH-1:0] yout;
  logic             cout, ar_zero, stack_full, stack_empty, stack_err;
  logic [CNTW-1:0]  sp_count;

  seq_slice_n #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .din         (din),
    .sel         (sel),
    .zero_n      (zero_n),
    .cin         (cin),
    .ar_ld       (ar_ld),
    .ar_dec      (ar_dec),
    .stk_en      (stk_en),
    .stk_push    (stk_push),
    .clr_err     (clr_err),
    .yout        (yout),
    .cout        (cout),
    .ar_zero     (ar_zero),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err),
    .sp_count    (sp_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model state
  int unsigned m_pc, m_ar;
  int unsigned m_stk[$];
  bit          m_err;
  bit          m_valid;

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Apply one cycle of inputs, compare combinational outputs with the model,
  // then advance model and DUT across one rising edge.
  task automatic cyc(input bit rs, input int unsigned d, input int unsigned s,
                     input bit zn, input bit ci, input bit ld, input bit dc,
                     input bit en, input bit ps, input bit clr);
    int unsigned mux, y, lim, old_pc;
    bit          new_err;
    @(negedge clock);
    reset = rs; din = d[WIDTH-1:0]; sel = s[1:0]; zero_n = zn; cin = ci;
    ar_ld = ld; ar_dec = dc; stk_en = en; stk_push = ps; clr_err = clr;
    #1;
    lim = (1 << WIDTH);
    case (s)
      0: mux = m_pc;
      1: mux = m_ar;
      2: mux = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 0;
      default: mux = d % lim;
    endcase
    y = zn ? mux : 0;
    if (m_valid) begin
      check("yout", 32'(yout), y);
      check("cout", 32'(cout), 32'(y == lim - 1));
      check("ar_zero", 32'(ar_zero), 32'(m_ar == 0));
      check("sp_count", 32'(sp_count), m_stk.size());
      check("full", 32'(stack_full), 32'(m_stk.size() == DEPTH));
      check("empty", 32'(stack_empty), 32'(m_stk.size() == 0));
      check("err", 32'(stack_err), 32'(m_err));
    end
    if (rs) begin
      m_pc = 0; m_ar = 0; m_err = 0; m_stk.delete(); m_valid = 1;
    end else if (m_valid) begin
      old_pc  = m_pc;
      new_err = 0;
      m_pc = (y + ci) % lim;
      if (ld) m_ar = d % lim;
      else if (dc && m_ar > 0) m_ar = m_ar - 1;
      if (en && ps) begin
        if (m_stk.size() == DEPTH) new_err = 1;
        else m_stk.push_back(old_pc);
      end else if (en) begin
        if (m_stk.size() == 0) new_err = 1;
        else void'(m_stk.pop_back());
      end
      if (new_err) m_err = 1;
      else if (clr) m_err = 0;
    end
    @(posedge clock);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; m_valid = 0;
    m_pc = 0; m_ar = 0; m_err = 0;
    reset = 1; din = '0; sel = '0; zero_n = 1; cin = 0;
    ar_ld = 0; ar_dec = 0; stk_en = 0; stk_push = 0; clr_err = 0;

    // Reset then free-running increment through wrap
    cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) cyc(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);

    // Call / return: reach PC=5, jump to 9 while pushing, then return
    cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 5, 3, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 9, 3, 1, 1, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 2, 1, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // Overflow: push PC=1..5, then clear the sticky error
    cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 1, 0, 0, 1, 1, 0);
    cyc(0, 0, 2, 1, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 2, 1, 0, 0, 0, 0, 0, 0);

    // Underflow with simultaneous clear
    cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 2, 1, 0, 0, 0, 1, 0, 1);
    cyc(0, 0, 2, 1, 0, 0, 0, 0, 0, 0);

    // AR load, saturating decrement, load priority
    cyc(0, 3, 1, 1, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 0, 0, 1, 0, 0, 0);
    cyc(0, 7, 1, 1, 0, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0, 0, 0, 0);

    // Forced zero, then reset colliding with a push
    cyc(0, 12, 3, 0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 1, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 80) == 0, $urandom, $urandom_range(0, 3),
          ($urandom % 8) != 0, $urandom % 2, ($urandom % 4) == 0,
          $urandom % 2, $urandom % 2, $urandom % 2, ($urandom % 6) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
